// File: rtl/ic_wdata_sched_pkg.sv
// Shared definitions for the per-slave W-data scheduler.
// Queue entries are packed as {mstr, len}, with mstr in the upper bits.
package ic_wdata_sched_pkg;

    localparam int MSTRS_DEF    = 4;
    localparam int LEN_BITS_DEF = 4;
    localparam int DEPTH_DEF    = 4;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MSTR_BITS_DEF = idx_bits(MSTRS_DEF);

    // Width of one ordering-queue entry {mstr, len}.
    function automatic int entry_bits(input int mstr_bits, input int len_bits);
        return mstr_bits + len_bits;
    endfunction

endpackage

// File: rtl/ic_wdata_sched_fifo.sv
// DEPTH-entry register FIFO holding the AW order for one slave port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ic_wdata_sched_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ic_wdata_sched.sv
// Per-slave W-data scheduler: routes master W bursts to the slave in AW order,
// regenerates WLAST from AWLEN and flags bursts whose WLAST disagrees.
module ic_wdata_sched
    import ic_wdata_sched_pkg::*;
#(
    parameter int MSTRS     = MSTRS_DEF,
    parameter int MSTR_BITS = idx_bits(MSTRS),
    parameter int DATA_BITS = 64,
    parameter int STRB_BITS = DATA_BITS / 8,
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = LEN_BITS_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       AWVALID,
    input  logic                       AWREADY,
    input  logic [MSTR_BITS-1:0]       AWMSTR,
    input  logic [LEN_BITS-1:0]        AWLEN,
    output logic                       AWSTALL,
    input  logic [MSTRS-1:0]           M_WVALID,
    output logic [MSTRS-1:0]           M_WREADY,
    input  logic [MSTRS*DATA_BITS-1:0] M_WDATA,
    input  logic [MSTRS*STRB_BITS-1:0] M_WSTRB,
    input  logic [MSTRS*ID_BITS-1:0]   M_WID,
    input  logic [MSTRS-1:0]           M_WLAST,
    output logic                       S_WVALID,
    output logic [DATA_BITS-1:0]       S_WDATA,
    output logic [STRB_BITS-1:0]       S_WSTRB,
    output logic [ID_BITS-1:0]         S_WID,
    output logic                       S_WLAST,
    input  logic                       S_WREADY,
    output logic                       LEN_ERR,
    output logic [MSTR_BITS-1:0]       ERR_MSTR
);

    localparam int EW = entry_bits(MSTR_BITS, LEN_BITS);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]        fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [MSTR_BITS-1:0] head_mstr;
    logic [LEN_BITS-1:0]  head_len;
    logic                 push;
    logic                 pop;
    logic                 beat;
    logic                 head_wlast;

    logic [LEN_BITS-1:0]  bcnt_q, bcnt_d;
    logic                 len_err_q, len_err_d;
    logic [MSTR_BITS-1:0] err_mstr_q, err_mstr_d;

    assign AWSTALL   = (fifo_count == CW'(DEPTH));
    assign push      = AWVALID & AWREADY & ~fifo_full;
    assign head_mstr = fifo_head[EW-1:LEN_BITS];
    assign head_len  = fifo_head[LEN_BITS-1:0];
    assign S_WLAST   = ~fifo_empty & (bcnt_q == head_len);
    assign beat      = S_WVALID & S_WREADY;
    assign pop       = beat & S_WLAST;
    assign LEN_ERR   = len_err_q;
    assign ERR_MSTR  = err_mstr_q;

    ic_wdata_sched_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({AWMSTR, AWLEN}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Zero-latency W routing from the master that owns the head entry.
    always_comb begin
        S_WVALID   = 1'b0;
        S_WDATA    = '0;
        S_WSTRB    = '0;
        S_WID      = '0;
        M_WREADY   = '0;
        head_wlast = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < MSTRS; i++) begin
                if (head_mstr == MSTR_BITS'(i)) begin
                    S_WVALID    = M_WVALID[i];
                    S_WDATA     = M_WDATA[i*DATA_BITS +: DATA_BITS];
                    S_WSTRB     = M_WSTRB[i*STRB_BITS +: STRB_BITS];
                    S_WID       = M_WID[i*ID_BITS +: ID_BITS];
                    M_WREADY[i] = S_WREADY;
                    head_wlast  = M_WLAST[i];
                end
            end
        end
    end

    // Beat counter and length-check next state.
    always_comb begin
        bcnt_d     = bcnt_q;
        len_err_d  = 1'b0;
        err_mstr_d = err_mstr_q;
        if (beat) begin
            bcnt_d = pop ? '0 : bcnt_q + LEN_BITS'(1);
            if (head_wlast != S_WLAST) begin
                len_err_d  = 1'b1;
                err_mstr_d = head_mstr;
            end
        end
    end

    // Beat counter and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q     <= '0;
            len_err_q  <= 1'b0;
            err_mstr_q <= '0;
        end else begin
            bcnt_q     <= bcnt_d;
            len_err_q  <= len_err_d;
            err_mstr_q <= err_mstr_d;
        end
    end

endmodule
